// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the frame buffer write port between the PPU pixel stream and a full-screen clear sequencer.
// Optional FB_BOUNDS_CHECK_EN: drop and count accepted pixels outside the screen.
module fb_write_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 144
) (
  input  logic       wrclock,
  input  logic       reset,
  input  logic       px_valid,
  output logic       px_ready,
  input  logic [7:0] px_x,
  input  logic [7:0] px_y,
  input  logic [1:0] px_color,
  input  logic       clear_req,
  input  logic [1:0] clear_color,
  output logic       busy,
  output logic       clear_done,
  output logic [7:0] fb_X_write,
  output logic [7:0] fb_Y_write,
  output logic [1:0] fb_in,
  output logic       fb_wren,
  output logic [7:0] drop_count
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  localparam logic [7:0] W8 = 8'(SCREEN_W);
  localparam logic [7:0] H8 = 8'(SCREEN_H);
  state_t state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [1:0] in_q, in_d, col_q, col_d;
  logic wren_q, wren_d;
  logic accept, last, oob;
  assign accept = px_valid & px_ready;
  // The output coordinate registers double as the clear raster counters.
  assign last = (state_q == CLEAR) && (x_q == W8 - 8'd1) && (y_q == H8 - 8'd1);
  always_ff @(posedge wrclock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      in_q <= '0;
      col_q <= '0;
      wren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      in_q <= in_d;
      col_q <= col_d;
      wren_q <= wren_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = clear_req ? CLEAR : IDLE;
      CLEAR:   state_d = last ? DONE : CLEAR;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    in_d = in_q;
    col_d = col_q;
    wren_d = 1'b0;
    if (state_q == IDLE && clear_req) begin
      x_d = '0;
      y_d = '0;
      in_d = clear_color;
      col_d = clear_color;
      wren_d = 1'b1;
    end else if (accept && !oob) begin
      x_d = px_x;
      y_d = px_y;
      in_d = px_color;
      wren_d = 1'b1;
    end else if (state_q == CLEAR && !last) begin
      x_d = (x_q == W8 - 8'd1) ? 8'd0 : x_q + 8'd1;
      y_d = (x_q == W8 - 8'd1) ? y_q + 8'd1 : y_q;
      in_d = col_q;
      wren_d = 1'b1;
    end
  end
  assign px_ready = ~reset & ~clear_req & (state_q == IDLE);
  assign busy = state_q == CLEAR;
  assign clear_done = state_q == DONE;
  assign fb_X_write = x_q;
  assign fb_Y_write = y_q;
  assign fb_in = in_q;
  assign fb_wren = wren_q;
`ifdef FB_BOUNDS_CHECK_EN
  logic [7:0] drop_q, drop_d;
  assign oob = (px_x >= W8) || (px_y >= H8);
  assign drop_d = (accept && oob && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  always_ff @(posedge wrclock) begin
    if (reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_count = drop_q;
`else
  assign oob = 1'b0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: randomized and directed checks of fb_write_arbiter against a raster-index reference model.
module tb_fb_write_arbiter;
  localparam int W = 160;
  localparam int H = 144;
`ifdef FB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic wrclock = 1'b0, reset = 1'b1, px_valid = 1'b0, clear_req = 1'b0;
  logic [7:0] px_x = '0, px_y = '0;
  logic [1:0] px_color = '0, clear_color = '0;
  logic px_ready, busy, clear_done, fb_wren;
  logic [7:0] fb_X_write, fb_Y_write, drop_count;
  logic [1:0] fb_in;
  int checks = 0, errors = 0;
  // reference model: mode 0 idle, 1 clearing, 2 done; clear position as a linear raster index
  int m_st = 0, m_idx = 0;
  logic [1:0] m_col = '0, m_in = '0;
  logic [7:0] m_x = '0, m_y = '0, m_drop = '0;
  logic m_wren = 1'b0;

  fb_write_arbiter dut (
    .wrclock(wrclock), .reset(reset), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .clear_done(clear_done),
    .fb_X_write(fb_X_write), .fb_Y_write(fb_Y_write), .fb_in(fb_in),
    .fb_wren(fb_wren), .drop_count(drop_count)
  );

  always #5 wrclock = ~wrclock;

  function automatic logic [28:0] dut_o();
    return {fb_wren, fb_X_write, fb_Y_write, fb_in, busy, clear_done, drop_count};
  endfunction

  function automatic logic [28:0] mod_o();
    return {m_wren, m_x, m_y, m_in, m_st == 1, m_st == 2, m_drop};
  endfunction

  function automatic logic m_ready();
    return !reset && !clear_req && m_st == 0;
  endfunction

  task automatic tick();
    if (reset) begin
      m_st = 0; m_wren = 0; m_x = 0; m_y = 0; m_in = 0; m_col = 0; m_drop = 0;
    end else if (m_st == 0) begin
      if (clear_req) begin
        m_st = 1; m_idx = 0; m_col = clear_color; m_wren = 1; m_x = 0; m_y = 0; m_in = clear_color;
      end else if (px_valid) begin
        if (BC && (px_x >= W || px_y >= H)) begin
          m_wren = 0;
          m_drop = (m_drop == 8'd255) ? m_drop : m_drop + 8'd1;
        end else begin
          m_wren = 1; m_x = px_x; m_y = px_y; m_in = px_color;
        end
      end else m_wren = 0;
    end else if (m_st == 1) begin
      if (m_idx == W * H - 1) begin
        m_st = 2; m_wren = 0;
      end else begin
        m_idx++; m_wren = 1; m_x = 8'(m_idx % W); m_y = 8'(m_idx / W); m_in = m_col;
      end
    end else begin
      m_st = 0; m_wren = 0;
    end
    @(posedge wrclock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; px_valid = 0; clear_req = 0;
    tick(); tick();
    checks++;
    if (dut_o() !== 29'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_o(), 29'd0);
    end
    checks++;
    if (px_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0", px_ready);
    end
    reset = 0;
    #1;
    checks++;
    if (px_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready got=%b exp=1", px_ready);
    end
  endtask

  task automatic test_single_pixel();
    px_valid = 1; px_x = 10; px_y = 20; px_color = 2;
    tick();
    px_valid = 0;
    checks++;
    if ({fb_wren, fb_X_write, fb_Y_write, fb_in} !== {1'b1, 8'd10, 8'd20, 2'd2}) begin
      errors++; $display("FAIL single_write got=%b/%0d/%0d/%0d exp=1/10/20/2", fb_wren, fb_X_write, fb_Y_write, fb_in);
    end
    tick();
    checks++;
    if (fb_wren !== 1'b0 || dut_o() !== mod_o()) begin
      errors++; $display("FAIL single_idle got=%h exp=%h", dut_o(), mod_o());
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < W; i++) begin
      px_valid = 1; px_x = 8'(i); px_y = 5; px_color = 2'($urandom);
      #1;
      checks++;
      if (px_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, px_ready);
      end
      tick();
      checks++;
      if (dut_o() !== mod_o() || fb_X_write !== 8'(i) || fb_Y_write !== 8'd5) begin
        errors++; $display("FAIL b2b_write i=%0d got=%h exp=%h", i, dut_o(), mod_o());
      end
      n += fb_wren;
    end
    px_valid = 0;
    checks++;
    if (n != W) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", n, W);
    end
  endtask

  task automatic test_clear();
    int n = 1, bad = 0;
    bit seen = 0;
    clear_req = 1; clear_color = 3;
    #1;
    checks++;
    if (px_ready !== 1'b0) begin
      errors++; $display("FAIL clear_ready_drop got=%b exp=0", px_ready);
    end
    tick();
    clear_req = 0;
    checks++;
    if ({fb_wren, fb_X_write, fb_Y_write, fb_in, busy} !== {1'b1, 8'd0, 8'd0, 2'd3, 1'b1}) begin
      errors++; $display("FAIL clear_first got=%h exp=%h", dut_o(), mod_o());
    end
    for (int c = 0; c < W * H + 50 && !seen; c++) begin
      clear_req = (c == 500);
      tick();
      clear_req = 0;
      if (dut_o() !== mod_o()) begin
        bad++;
        if (bad < 5) $display("FAIL clear_cycle c=%0d got=%h exp=%h", c, dut_o(), mod_o());
      end
      if (fb_wren) begin
        if (n == 160 && (fb_X_write !== 8'd0 || fb_Y_write !== 8'd1)) begin
          bad++; $display("FAIL clear_write160 got=%0d,%0d exp=0,1", fb_X_write, fb_Y_write);
        end
        if (fb_in !== 2'd3) bad++;
        n++;
      end
      seen = clear_done;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL clear_sequence got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (!seen || n != W * H) begin
      errors++; $display("FAIL clear_length got=%0d writes done=%b exp=%0d done=1", n, seen, W * H);
    end
    checks++;
    if ({fb_X_write, fb_Y_write, fb_wren, busy, px_ready} !== {8'd159, 8'd143, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clear_last got=%0d,%0d wren=%b busy=%b rdy=%b exp=159,143,0,0,0", fb_X_write, fb_Y_write, fb_wren, busy, px_ready);
    end
    tick();
    checks++;
    if (clear_done !== 1'b0 || px_ready !== 1'b1 || dut_o() !== mod_o()) begin
      errors++; $display("FAIL clear_after got=%h done=%b rdy=%b exp=%h done=0 rdy=1", dut_o(), clear_done, px_ready, mod_o());
    end
  endtask

  task automatic test_clear_vs_pixel();
    int bad = 0;
    bit seen = 0;
    clear_req = 1; clear_color = 1; px_valid = 1; px_x = 7; px_y = 7; px_color = 2;
    #1;
    checks++;
    if (px_ready !== 1'b0) begin
      errors++; $display("FAIL cvp_ready got=%b exp=0", px_ready);
    end
    tick();
    clear_req = 0;
    checks++;
    if ({fb_X_write, fb_Y_write, fb_in} !== {8'd0, 8'd0, 2'd1}) begin
      errors++; $display("FAIL cvp_first got=%0d,%0d,%0d exp=0,0,1", fb_X_write, fb_Y_write, fb_in);
    end
    for (int c = 0; c < W * H + 50 && !seen; c++) begin
      if (px_ready !== 1'b0) bad++;
      tick();
      if (dut_o() !== mod_o()) bad++;
      seen = clear_done;
    end
    checks++;
    if (bad != 0 || !seen) begin
      errors++; $display("FAIL cvp_clear got=%0d bad done=%b exp=0 bad done=1", bad, seen);
    end
    tick();
    checks++;
    if (px_ready !== 1'b1 || fb_wren !== 1'b0) begin
      errors++; $display("FAIL cvp_idle got=rdy %b wren %b exp=rdy 1 wren 0", px_ready, fb_wren);
    end
    tick();
    px_valid = 0;
    checks++;
    if ({fb_wren, fb_X_write, fb_Y_write, fb_in} !== {1'b1, 8'd7, 8'd7, 2'd2}) begin
      errors++; $display("FAIL cvp_pixel got=%b/%0d/%0d/%0d exp=1/7/7/2", fb_wren, fb_X_write, fb_Y_write, fb_in);
    end
  endtask

  task automatic test_reset_mid_clear();
    int dones = 0;
    clear_req = 1; clear_color = 2;
    tick();
    clear_req = 0;
    for (int c = 0; c < 999; c++) tick();
    checks++;
    if (busy !== 1'b1 || dut_o() !== mod_o()) begin
      errors++; $display("FAIL rmc_before got=%h exp=%h", dut_o(), mod_o());
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (fb_wren !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++; $display("FAIL rmc_abort got=wren %b busy %b done %b exp=0 0 0", fb_wren, busy, clear_done);
    end
    for (int c = 0; c < 50; c++) begin
      tick();
      dones += clear_done + fb_wren;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL rmc_quiet got=%0d pulses exp=0", dones);
    end
  endtask

  task automatic test_bounds();
    logic [15:0] pts [3];
    int n = 0;
    pts[0] = {8'd160, 8'd0}; pts[1] = {8'd0, 8'd144}; pts[2] = {8'd159, 8'd143};
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      px_valid = 1; {px_x, px_y} = pts[i]; px_color = 1;
      tick();
      n += fb_wren;
      checks++;
      if (dut_o() !== mod_o()) begin
        errors++; $display("FAIL bounds_pt%0d got=%h exp=%h", i, dut_o(), mod_o());
      end
    end
    px_valid = 0;
    checks++;
    if (n != (BC ? 1 : 3) || drop_count !== (BC ? 8'd2 : 8'd0) || fb_X_write !== 8'd159 || fb_Y_write !== 8'd143) begin
      errors++; $display("FAIL bounds_summary got=%0d writes drop %0d at %0d,%0d exp=%0d writes drop %0d at 159,143", n, drop_count, fb_X_write, fb_Y_write, BC ? 1 : 3, BC ? 2 : 0);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      px_valid = $urandom_range(0, 3) != 0;
      px_x = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, W - 1));
      px_y = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, H - 1));
      px_color = 2'($urandom);
      #1;
      if (px_ready !== m_ready()) bad++;
      tick();
      if (dut_o() !== mod_o()) begin
        bad++;
        if (bad < 5) $display("FAIL random c=%0d got=%h exp=%h", c, dut_o(), mod_o());
      end
    end
    reset = 0; px_valid = 0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_total got=%0d bad exp=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_clear();
    test_clear_vs_pixel();
    test_reset_mid_clear();
    test_bounds();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
